// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   arb_state_t         - arbiter state encoding (IDLE / GRANT)
//   UART_ARB_NREQ       - default number of arbiter requesters
//   UART_ARB_IDLE_TO    - default locked-grant idle timeout in cycles
//   UART_TX_FIFO_DEPTH  - depth of the transmitter TX FIFO
package uart_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned UART_ARB_NREQ      = 4;
  localparam int unsigned UART_ARB_IDLE_TO   = 255;
  localparam int unsigned UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the
// UART TX arbiter.
//   req_valid/req_data/req_last  requester bytes in (NREQ lanes, 8 bits each)
//   req_ready                    per-requester accept strobe
//   tx_data/tx_en                write port into the transmitter FIFO
//   tx_full                      transmitter FIFO full
//   grant_valid/grant_id         current owner of the transmitter
// Modports: master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = UART_ARB_NREQ
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_full;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

  modport master (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_data, tx_en, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_data, tx_en, grant_valid, grant_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   req    - request vector
//   last   - index of the previous winner; search starts at last+1
//   win_oh - one-hot winner (all zero when no request)
//   win_id - index of the winner (0 when no request)
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = UART_ARB_NREQ,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_id
);

  logic        found;
  int unsigned idx;

  always_comb begin
    win_oh = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && req[IDW'(idx)]) begin
        found              = 1'b1;
        win_oh[IDW'(idx)]  = 1'b1;
        win_id             = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter (and its
// TX FIFO) between NREQ byte-stream requesters.
//   clk   - system clock (same as the transmitter)
//   RSTn  - asynchronous active-low reset
//   bus   - uart_tx_arbiter_if.master: requester lanes, transmitter write
//           port (tx_data/tx_en), FIFO-full back-pressure, grant status
// Parameters: NREQ (2..8), IDLE_TO (1..255, lock build only).
// Build option: define UART_ARB_LOCK_EN to hold a grant for a whole packet
// (until req_last transfers or the owner idles for IDLE_TO cycles).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ    = UART_ARB_NREQ,
  parameter int unsigned IDLE_TO = UART_ARB_IDLE_TO
) (
  input  logic              clk,
  input  logic              RSTn,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  grant_id_q, grant_id_nxt;
  logic [IDW-1:0]  last_q, last_nxt;
  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_id;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            xfer;
  logic            release_g;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req_valid),
    .last   (last_q),
    .win_oh (pick_oh),
    .win_id (pick_id)
  );

  assign sel_valid = bus.req_valid[grant_id_q];
  assign sel_data  = bus.req_data[{grant_id_q, 3'b000} +: 8];
  assign xfer      = (state == ARB_GRANT) && sel_valid && !bus.tx_full;

`ifdef UART_ARB_LOCK_EN
  logic [7:0] to_cnt_q, to_cnt_nxt;
  logic       sel_last;
  logic       to_inc;
  logic       timeout;

  assign sel_last = bus.req_last[grant_id_q];
  // Idle cycles of the owner count only while the FIFO can accept data.
  assign to_inc   = (state == ARB_GRANT) && !sel_valid && !bus.tx_full;
  // Release on the edge where the counter reaches IDLE_TO.
  assign timeout  = to_inc && (to_cnt_q == 8'(IDLE_TO - 1));
  assign release_g = (xfer && sel_last) || timeout;

  always_comb begin
    to_cnt_nxt = to_cnt_q;
    if (state != ARB_GRANT || xfer) begin
      to_cnt_nxt = '0;
    end else if (to_inc && to_cnt_q != '1) begin
      to_cnt_nxt = to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_nxt;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign release_g   = xfer;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ARB_IDLE;
      grant_id_q <= '0;
      last_q     <= IDW'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id_q <= grant_id_nxt;
      last_q     <= last_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id_q;
    last_nxt     = last_q;
    case (state)
      ARB_IDLE: begin
        if (|pick_oh) begin
          grant_id_nxt = pick_id;
          last_nxt     = pick_id;
          state_nxt    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (release_g) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready             = '0;
    bus.req_ready[grant_id_q] = xfer;
    bus.tx_en                 = xfer;
    bus.tx_data               = (state == ARB_GRANT) ? sel_data : '0;
    bus.grant_valid           = (state == ARB_GRANT);
    bus.grant_id              = grant_id_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDLE_TO = 255;

  logic clk = 1'b0;
  logic RSTn;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TO(IDLE_TO)) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ntx   = 0;
  int cyc   = 0;
  int stamps[$];
  logic [15:0] expq[$];   // {id, data}

  logic [8:0] rbuf[NREQ][32];  // {last, data}
  int rhd[NREQ];
  int rtail[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic enq(input int r, input logic [7:0] d, input logic l);
    rbuf[r][rtail[r]] = {l, d};
    rtail[r]++;
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d);
    expq.push_back({8'(id), d});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rhd[i] < rtail[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = rbuf[i][rhd[i]][7:0];
        bus.req_last[i]        = rbuf[i][rhd[i]][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic wait_tx(input int target, input int budget, input string name);
    int k = 0;
    while (ntx < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (ntx < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d strobes expected %0d", name, ntx, target);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, %0d bytes outstanding expected 0", name, expq.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant_valid"}, int'(bus.grant_valid), 0);
    check({tag, "_tx_en"},       int'(bus.tx_en),       0);
    check({tag, "_req_ready"},   int'(bus.req_ready),   0);
    check({tag, "_tx_data"},     int'(bus.tx_data),     0);
    check({tag, "_grant_id"},    int'(bus.grant_id),    0);
  endtask

  // Requester model: pops a byte once its req_ready was seen before the edge.
  initial begin : driver
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && RSTn) rhd[i]++;
      end
      drive();
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    logic [15:0] e;
    logic [NREQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (RSTn === 1'b1) begin
        n_cmp++;
        if ($countones(bus.req_ready) > 1) begin
          n_bad++;
          $display("FAIL ready_onehot: req_ready=%b expected one-hot or zero", bus.req_ready);
        end
        if (bus.tx_en) begin
          stamps.push_back(cyc);
          ntx++;
          n_cmp++;
          if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_tx: id=%0d data=0x%0h expected no strobe", bus.grant_id, bus.tx_data);
          end else begin
            e = expq.pop_front();
            exp_rdy = NREQ'(1) << e[15:8];
            if (bus.grant_id != e[15:8] || bus.tx_data != e[7:0] || bus.req_ready != exp_rdy) begin
              n_bad++;
              $display("FAIL tx_byte: got id=%0d data=0x%0h ready=%b expected id=%0d data=0x%0h ready=%b",
                       bus.grant_id, bus.tx_data, bus.req_ready, e[15:8], e[7:0], exp_rdy);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int s;
    RSTn        = 1'b0;
    bus.tx_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rhd[i]   = 0;
      rtail[i] = 0;
    end
    drive();
    #2;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 RSTn = 1'b1;

    // Single requester 2, unlocked bytes two cycles apart.
    t0 = ntx;
    enq(2, 8'h41, 1'b1); enq(2, 8'h42, 1'b1);
    expect_tx(2, 8'h41); expect_tx(2, 8'h42);
    drive();
    check("t1_no_grant_before_edge", int'(bus.grant_valid), 0);
    @(posedge clk); #1;
    check("t1_grant_valid", int'(bus.grant_valid), 1);
    check("t1_grant_id", int'(bus.grant_id), 2);
    check("t1_first_tx_en", int'(bus.tx_en), 1);
    wait_tx(t0 + 2, 20, "t1_wait");
    if (ntx >= t0 + 2) check("t1_gap", stamps[t0+1] - stamps[t0], 2);
    drain(20, "t1_drain");

    // Move the round-robin pointer to 3 so requester 0 is next.
    enq(3, 8'h3F, 1'b1); expect_tx(3, 8'h3F);
    drive();
    drain(20, "prime_drain");

    // Round robin among 0,1,3 held valid continuously.
    t0 = ntx;
    enq(0, 8'hA0, 1'b1); enq(0, 8'hA1, 1'b1);
    enq(1, 8'hB0, 1'b1); enq(1, 8'hB1, 1'b1);
    enq(3, 8'hD0, 1'b1); enq(3, 8'hD1, 1'b1);
    expect_tx(0, 8'hA0); expect_tx(1, 8'hB0); expect_tx(3, 8'hD0);
    expect_tx(0, 8'hA1); expect_tx(1, 8'hB1); expect_tx(3, 8'hD1);
    drive();
    drain(40, "rr_drain");
    if (ntx >= t0 + 6) check("rr_span", stamps[t0+5] - stamps[t0], 10);

    // tx_full stall for 10 cycles; 0x5A must be written exactly once.
    t0 = ntx;
    enq(1, 8'h59, 1'b1); enq(1, 8'h5A, 1'b1); enq(1, 8'h5B, 1'b1);
    expect_tx(1, 8'h59); expect_tx(1, 8'h5A); expect_tx(1, 8'h5B);
    drive();
    wait_tx(t0 + 1, 20, "stall_wait");
    bus.tx_full = 1'b1;
    s = ntx;
    repeat (10) @(posedge clk);
    #1;
    check("stall_no_tx_en", ntx - s, 0);
    check("stall_grant_held", int'(bus.grant_valid), 1);
    check("stall_grant_id", int'(bus.grant_id), 1);
    check("stall_ready_low", int'(bus.req_ready), 0);
    bus.tx_full = 1'b0;
    drain(20, "stall_drain");
    check("stall_total", ntx - t0, 3);

`ifdef UART_ARB_LOCK_EN
    // Pointer to 0 so requester 1 beats pending requester 0.
    enq(0, 8'h0F, 1'b1); expect_tx(0, 8'h0F);
    drive();
    drain(20, "lock_prime_drain");

    t0 = ntx;
    enq(1, 8'h10, 1'b0); enq(1, 8'h11, 1'b0); enq(1, 8'h12, 1'b1);
    enq(0, 8'h05, 1'b1);
    expect_tx(1, 8'h10); expect_tx(1, 8'h11); expect_tx(1, 8'h12);
    expect_tx(0, 8'h05);
    drive();
    drain(40, "lock_pkt_drain");
    if (ntx >= t0 + 3) begin
      check("lock_b2b_1", stamps[t0+1] - stamps[t0], 1);
      check("lock_b2b_2", stamps[t0+2] - stamps[t0+1], 1);
    end

    // Owner 3 goes idle mid-packet: released after IDLE_TO idle cycles.
    t0 = ntx;
    enq(3, 8'h20, 1'b0); enq(0, 8'h06, 1'b1);
    expect_tx(3, 8'h20); expect_tx(0, 8'h06);
    drive();
    drain(IDLE_TO + 40, "timeout_drain");
    if (ntx >= t0 + 2) check("timeout_gap", stamps[t0+1] - stamps[t0], int'(IDLE_TO) + 2);

    // Asynchronous reset in the middle of a stalled locked packet.
    t0 = ntx;
    enq(2, 8'h30, 1'b0); enq(2, 8'h31, 1'b0); enq(2, 8'h32, 1'b0); enq(2, 8'h33, 1'b1);
    expect_tx(2, 8'h30);
    drive();
    wait_tx(t0 + 1, 20, "rst_wait");
    bus.tx_full = 1'b1;
    enq(0, 8'h01, 1'b1);
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked_valid", int'(bus.grant_valid), 1);
    check("rst_locked_id", int'(bus.grant_id), 2);
    #1 RSTn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    RSTn = 1'b1;
    bus.tx_full = 1'b0;
    expect_tx(0, 8'h01);
    expect_tx(2, 8'h31); expect_tx(2, 8'h32); expect_tx(2, 8'h33);
    drain(40, "rst_drain");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("final_outstanding", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
